// File: rtl/qcs_dyn_pre_rd_seq.sv
// qcs_dyn_pre_rd_seq: per-chain sweep of present 20 MHz subbands, SEG_LEN
// sequential preamble reads per subband, with stall hold and done pulse.
// Optional build macro: QCS_DYN_PRE_RD_SEQ_ERR_CHK_EN enables the illegal
// configuration check in CHECK (cfg_err pulse, abort to IDLE).
module qcs_dyn_pre_rd_seq #(
   parameter int unsigned ADDR_DW   = 8,
   parameter int unsigned BW_W      = 2,
   parameter int unsigned GAMMA_W   = 4,
   parameter int unsigned SUBBAND_W = 4,
   parameter int unsigned SEG_LEN   = 64
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [BW_W-1:0]      txconfig_bw,
   input  logic [BW_W-1:0]      sys_bw_mode,
   input  logic [SUBBAND_W-1:0] config_mu_subband_present,
   input  logic [GAMMA_W-1:0]   config_gamma_rotation,
   input  logic [3:0]           n_tx,
   input  logic                 stall,
   output logic                 nhtp_re,
   output logic [ADDR_DW-1:0]   nhtp_raddr,
   output logic                 nhtp_gamma,
   output logic                 nhtp_4ch,
   output logic                 busy,
   output logic                 done,
   output logic                 cfg_err
);

   localparam int unsigned SAMP_W = $clog2(SEG_LEN);
   localparam int unsigned SB_W   = $clog2(SUBBAND_W);
   localparam int unsigned FULL_W = SB_W + SAMP_W;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CHECK   = 3'd1;
   localparam logic [2:0] S_READ    = 3'd2;
   localparam logic [2:0] S_NEXT_SB = 3'd3;
   localparam logic [2:0] S_NEXT_TX = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   logic [2:0]           r_state;
   logic [2:0]           w_state_nxt;

   logic [BW_W-1:0]      r_bw;
   logic [BW_W-1:0]      r_sys;
   logic [SUBBAND_W-1:0] r_mask;
   logic [GAMMA_W-1:0]   r_gamma_cfg;
   logic [3:0]           r_ntx;
   logic [SB_W-1:0]      r_sb;
   logic [SAMP_W-1:0]    r_sample;
   logic [3:0]           r_chain;

   logic                 r_re;
   logic [ADDR_DW-1:0]   r_raddr;
   logic                 r_gamma_o;
   logic                 r_4ch;
   logic                 r_busy;
   logic                 r_done;

   logic [BW_W-1:0]      w_eff_bw;
   logic [SUBBAND_W-1:0] w_present;
   logic                 w_first_found;
   logic [SB_W-1:0]      w_first_idx;
   logic                 w_next_found;
   logic [SB_W-1:0]      w_next_idx;
   logic [3:0]           w_ntx_eff;
   logic                 w_more_chain;
   logic                 w_last_sample;
   logic                 w_rd;
   logic [FULL_W-1:0]    w_addr_full;
   logic                 w_cfg_err_nxt;

   // Effective bandwidth (code 3 behaves as 80 MHz) and present-and-active subbands
   always_comb begin
      w_eff_bw  = (r_bw > BW_W'(2)) ? BW_W'(2) : r_bw;
      w_present = '0;
      for (int i = 0; i < int'(SUBBAND_W); i++) begin
         w_present[i] = r_mask[i] && (i < (1 << w_eff_bw));
      end
   end

   // Lowest present subband overall and lowest present subband above the current one
   always_comb begin
      w_first_found = 1'b0;
      w_first_idx   = '0;
      w_next_found  = 1'b0;
      w_next_idx    = '0;
      for (int i = int'(SUBBAND_W) - 1; i >= 0; i--) begin
         if (w_present[i]) begin
            w_first_found = 1'b1;
            w_first_idx   = SB_W'(i);
         end
         if (w_present[i] && (i > int'(r_sb))) begin
            w_next_found = 1'b1;
            w_next_idx   = SB_W'(i);
         end
      end
   end

   assign w_ntx_eff     = (r_ntx == 4'd0) ? 4'd1 : r_ntx;
   assign w_more_chain  = ({1'b0, r_chain} + 5'd1) < {1'b0, w_ntx_eff};
   assign w_last_sample = (r_sample == SAMP_W'(SEG_LEN - 1));
   assign w_rd          = (r_state == S_READ) && !stall;
   assign w_addr_full   = {r_sb, r_sample};

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state logic; the final segment of the final chain goes straight to
   // DONE so that done lands in the cycle right after the last read
   always_comb begin
      w_state_nxt   = r_state;
      w_cfg_err_nxt = 1'b0;
      case (r_state)
         S_IDLE:    if (start) w_state_nxt = S_CHECK;
         S_CHECK: begin
`ifdef QCS_DYN_PRE_RD_SEQ_ERR_CHK_EN
            if ((r_chain == 4'd0) && ((r_bw > r_sys) || !w_first_found)) begin
               w_cfg_err_nxt = 1'b1;
               w_state_nxt   = S_IDLE;
            end else
`endif
            if (w_first_found) w_state_nxt = S_READ;
            else               w_state_nxt = S_DONE;
         end
         S_READ:    if (w_rd && w_last_sample) w_state_nxt = S_NEXT_SB;
         S_NEXT_SB: begin
            if (w_next_found)      w_state_nxt = S_READ;
            else if (w_more_chain) w_state_nxt = S_NEXT_TX;
            else                   w_state_nxt = S_DONE;
         end
         S_NEXT_TX: begin
            if (w_more_chain) w_state_nxt = S_CHECK;
            else              w_state_nxt = S_DONE;
         end
         S_DONE:    w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   // Config latch and sample/subband/chain counters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_bw        <= '0;
         r_sys       <= '0;
         r_mask      <= '0;
         r_gamma_cfg <= '0;
         r_ntx       <= '0;
         r_sb        <= '0;
         r_sample    <= '0;
         r_chain     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_bw        <= txconfig_bw;
                  r_sys       <= sys_bw_mode;
                  r_mask      <= config_mu_subband_present;
                  r_gamma_cfg <= config_gamma_rotation;
                  r_ntx       <= n_tx;
                  r_sb        <= '0;
                  r_sample    <= '0;
                  r_chain     <= '0;
               end
            end
            S_CHECK: begin
               r_sample <= '0;
               if (w_first_found) r_sb <= w_first_idx;
            end
            S_READ: begin
               if (!stall) r_sample <= w_last_sample ? '0 : r_sample + SAMP_W'(1);
            end
            S_NEXT_SB: if (w_next_found) r_sb <= w_next_idx;
            S_NEXT_TX: if (w_more_chain) r_chain <= r_chain + 4'd1;
            default: ;
         endcase
      end
   end

   // Registered read port and status outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_re      <= 1'b0;
         r_raddr   <= '0;
         r_gamma_o <= 1'b0;
         r_4ch     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_re      <= w_rd;
         if (w_rd) r_raddr <= ADDR_DW'(w_addr_full);
         r_gamma_o <= w_rd ? r_gamma_cfg[r_sb] : 1'b0;
         r_4ch     <= (r_ntx > 4'd4);
         r_busy    <= (w_state_nxt != S_IDLE);
         r_done    <= (w_state_nxt == S_DONE);
      end
   end

`ifdef QCS_DYN_PRE_RD_SEQ_ERR_CHK_EN
   logic r_cfg_err;

   // One-cycle illegal-configuration pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_cfg_err <= 1'b0;
      else          r_cfg_err <= w_cfg_err_nxt;
   end

   assign cfg_err = r_cfg_err;
`else
   logic w_unused_cfg;
   assign w_unused_cfg = (^r_sys) ^ w_cfg_err_nxt;
   assign cfg_err      = 1'b0;
`endif

   assign nhtp_re    = r_re;
   assign nhtp_raddr = r_raddr;
   assign nhtp_gamma = r_gamma_o;
   assign nhtp_4ch   = r_4ch;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule

// File: tb/tb_qcs_dyn_pre_rd_seq.sv
// Directed self-checking bench for qcs_dyn_pre_rd_seq.
module tb_qcs_dyn_pre_rd_seq;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic [1:0] txconfig_bw;
   logic [1:0] sys_bw_mode;
   logic [3:0] mask;
   logic [3:0] gamma;
   logic [3:0] n_tx;
   logic       stall;
   logic       nhtp_re;
   logic [7:0] nhtp_raddr;
   logic       nhtp_gamma;
   logic       nhtp_4ch;
   logic       busy;
   logic       done;
   logic       cfg_err;

   int n_cmp = 0;
   int n_mis = 0;

   bit         q_re[$];
   logic [7:0] q_ad[$];
   bit         q_bs[$];
   bit         q_er[$];
   logic [7:0] q_rd[$];
   int timed_out, first_re, last_re, n_done, done_idx, n_err, n_gam, gam_out;

   qcs_dyn_pre_rd_seq dut (
      .clk                       (clk),
      .reset_n                   (reset_n),
      .start                     (start),
      .txconfig_bw               (txconfig_bw),
      .sys_bw_mode               (sys_bw_mode),
      .config_mu_subband_present (mask),
      .config_gamma_rotation     (gamma),
      .n_tx                      (n_tx),
      .stall                     (stall),
      .nhtp_re                   (nhtp_re),
      .nhtp_raddr                (nhtp_raddr),
      .nhtp_gamma                (nhtp_gamma),
      .nhtp_4ch                  (nhtp_4ch),
      .busy                      (busy),
      .done                      (done),
      .cfg_err                   (cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Launch one sequence from the current negedge and record a per-cycle trace
   // (index 0 = cycle after start is sampled) until busy drops.
   task automatic run_seq(input logic [1:0] bw, input logic [1:0] sys, input logic [3:0] msk,
                          input logic [3:0] gam, input logic [3:0] ntx,
                          input int st_addr, input int st_len, input bit noise);
      int  left;
      bit  stalled;
      q_re.delete(); q_ad.delete(); q_bs.delete(); q_er.delete(); q_rd.delete();
      timed_out = 1; first_re = -1; last_re = -1; n_done = 0; done_idx = -1;
      n_err = 0; n_gam = 0; gam_out = 0; left = 0; stalled = 0;
      txconfig_bw = bw; sys_bw_mode = sys; mask = msk; gamma = gam; n_tx = ntx;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (noise) begin
         txconfig_bw = 2'd2; sys_bw_mode = 2'd2; mask = 4'hf; gamma = 4'hf; n_tx = 4'd6;
      end
      for (int c = 0; c < 3000; c++) begin
         q_re.push_back(nhtp_re); q_ad.push_back(nhtp_raddr);
         q_bs.push_back(busy);    q_er.push_back(cfg_err);
         if (nhtp_re) begin
            q_rd.push_back(nhtp_raddr);
            if (first_re < 0) first_re = c;
            last_re = c;
         end
         if (done) begin n_done++; done_idx = c; end
         if (cfg_err) n_err++;
         if (nhtp_gamma) n_gam++;
         if (nhtp_gamma && !nhtp_re) gam_out++;
         if (!busy) begin timed_out = 0; break; end
         if (left > 0) begin
            left--;
            if (left == 0) stall = 1'b0;
         end else if (!stalled && st_len > 0 && nhtp_re && nhtp_raddr == 8'(st_addr)) begin
            stall = 1'b1; left = st_len; stalled = 1'b1;
         end
         start = noise && (c % 5 == 3);
         @(negedge clk);
      end
      start = 1'b0; stall = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b1; start = 1'b0; stall = 1'b0;
      txconfig_bw = '0; sys_bw_mode = '0; mask = '0; gamma = '0; n_tx = '0;
      #2 reset_n = 1'b0;
      #1;
      n_cmp++; if (nhtp_re !== 1'b0) begin n_mis++; $display("FAIL reset_re got=%b exp=0", nhtp_re); end
      n_cmp++; if (nhtp_raddr !== 8'd0) begin n_mis++; $display("FAIL reset_raddr got=%0d exp=0", nhtp_raddr); end
      n_cmp++; if (nhtp_gamma !== 1'b0) begin n_mis++; $display("FAIL reset_gamma got=%b exp=0", nhtp_gamma); end
      n_cmp++; if (nhtp_4ch !== 1'b0) begin n_mis++; $display("FAIL reset_4ch got=%b exp=0", nhtp_4ch); end
      n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_mis++; $display("FAIL reset_done got=%b exp=0", done); end
      n_cmp++; if (cfg_err !== 1'b0) begin n_mis++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_single_20();
      run_seq(2'd0, 2'd0, 4'b0001, 4'b0000, 4'd1, -1, 0, 1'b0);
      n_cmp++; if (timed_out !== 0) begin n_mis++; $display("FAIL single_timeout got=%0d exp=0", timed_out); end
      n_cmp++; if (q_rd.size() !== 64) begin n_mis++; $display("FAIL single_nreads got=%0d exp=64", q_rd.size()); end
      for (int i = 0; i < q_rd.size() && i < 64; i++) begin
         n_cmp++; if (q_rd[i] !== 8'(i)) begin n_mis++; $display("FAIL single_addr[%0d] got=%0d exp=%0d", i, q_rd[i], i); end
      end
      n_cmp++; if (first_re !== 2) begin n_mis++; $display("FAIL single_first_re got=%0d exp=2", first_re); end
      n_cmp++; if (q_bs[0] !== 1'b1) begin n_mis++; $display("FAIL single_busy_check got=%b exp=1", q_bs[0]); end
      n_cmp++; if (n_done !== 1) begin n_mis++; $display("FAIL single_ndone got=%0d exp=1", n_done); end
      n_cmp++; if (done_idx !== 66) begin n_mis++; $display("FAIL single_done_idx got=%0d exp=66", done_idx); end
      n_cmp++; if (nhtp_4ch !== 1'b0) begin n_mis++; $display("FAIL single_4ch got=%b exp=0", nhtp_4ch); end
   endtask

   task automatic test_skip_80();
      int sbl[3] = '{0, 1, 3};
      run_seq(2'd2, 2'd2, 4'b1011, 4'b0100, 4'd1, -1, 0, 1'b0);
      n_cmp++; if (timed_out !== 0) begin n_mis++; $display("FAIL skip_timeout got=%0d exp=0", timed_out); end
      n_cmp++; if (q_rd.size() !== 192) begin n_mis++; $display("FAIL skip_nreads got=%0d exp=192", q_rd.size()); end
      for (int i = 0; i < q_rd.size() && i < 192; i++) begin
         n_cmp++;
         if (q_rd[i] !== 8'(sbl[i / 64] * 64 + i % 64)) begin
            n_mis++; $display("FAIL skip_addr[%0d] got=%0d exp=%0d", i, q_rd[i], sbl[i / 64] * 64 + i % 64);
         end
      end
      n_cmp++; if (n_gam !== 0) begin n_mis++; $display("FAIL skip_gamma_cnt got=%0d exp=0", n_gam); end
      n_cmp++; if (n_done !== 1) begin n_mis++; $display("FAIL skip_ndone got=%0d exp=1", n_done); end
   endtask

   task automatic test_multichain();
      run_seq(2'd1, 2'd1, 4'b0011, 4'b0010, 4'd6, -1, 0, 1'b0);
      n_cmp++; if (timed_out !== 0) begin n_mis++; $display("FAIL multi_timeout got=%0d exp=0", timed_out); end
      n_cmp++; if (q_rd.size() !== 768) begin n_mis++; $display("FAIL multi_nreads got=%0d exp=768", q_rd.size()); end
      for (int i = 0; i < q_rd.size() && i < 768; i++) begin
         n_cmp++; if (q_rd[i] !== 8'(i % 128)) begin n_mis++; $display("FAIL multi_addr[%0d] got=%0d exp=%0d", i, q_rd[i], i % 128); end
      end
      n_cmp++; if (nhtp_4ch !== 1'b1) begin n_mis++; $display("FAIL multi_4ch got=%b exp=1", nhtp_4ch); end
      n_cmp++; if (n_done !== 1) begin n_mis++; $display("FAIL multi_ndone got=%0d exp=1", n_done); end
      n_cmp++; if (n_gam !== 384) begin n_mis++; $display("FAIL multi_gamma_cnt got=%0d exp=384", n_gam); end
      n_cmp++; if (gam_out !== 0) begin n_mis++; $display("FAIL multi_gamma_no_re got=%0d exp=0", gam_out); end
   endtask

   task automatic test_stall();
      int k;
      run_seq(2'd0, 2'd0, 4'b0001, 4'b0000, 4'd1, 20, 5, 1'b0);
      k = -1;
      for (int i = 0; i < q_re.size(); i++) begin
         if (q_re[i] && q_ad[i] == 8'd20 && k < 0) k = i;
      end
      n_cmp++; if (k !== 22) begin n_mis++; $display("FAIL stall_addr20_idx got=%0d exp=22", k); end
      if (k >= 0 && k + 6 < q_re.size()) begin
         for (int j = 1; j <= 5; j++) begin
            n_cmp++; if (q_re[k + j] !== 1'b0) begin n_mis++; $display("FAIL stall_re[%0d] got=%b exp=0", j, q_re[k + j]); end
            n_cmp++; if (q_ad[k + j] !== 8'd20) begin n_mis++; $display("FAIL stall_addr[%0d] got=%0d exp=20", j, q_ad[k + j]); end
         end
         n_cmp++; if (q_re[k + 6] !== 1'b1) begin n_mis++; $display("FAIL stall_resume_re got=%b exp=1", q_re[k + 6]); end
         n_cmp++; if (q_ad[k + 6] !== 8'd21) begin n_mis++; $display("FAIL stall_resume_addr got=%0d exp=21", q_ad[k + 6]); end
      end
      n_cmp++; if (q_rd.size() !== 64) begin n_mis++; $display("FAIL stall_nreads got=%0d exp=64", q_rd.size()); end
      for (int i = 0; i < q_rd.size() && i < 64; i++) begin
         n_cmp++; if (q_rd[i] !== 8'(i)) begin n_mis++; $display("FAIL stall_seq[%0d] got=%0d exp=%0d", i, q_rd[i], i); end
      end
      n_cmp++; if (done_idx !== 71) begin n_mis++; $display("FAIL stall_done_idx got=%0d exp=71", done_idx); end
      n_cmp++; if (nhtp_4ch !== 1'b0) begin n_mis++; $display("FAIL stall_4ch_relatch got=%b exp=0", nhtp_4ch); end
   endtask

   task automatic test_cfg();
`ifdef QCS_DYN_PRE_RD_SEQ_ERR_CHK_EN
      run_seq(2'd2, 2'd1, 4'b1111, 4'b0000, 4'd1, -1, 0, 1'b0);
      n_cmp++; if (n_err !== 1) begin n_mis++; $display("FAIL err_bw_pulses got=%0d exp=1", n_err); end
      n_cmp++; if (q_er.size() < 2 || q_er[1] !== 1'b1) begin n_mis++; $display("FAIL err_bw_idx got_len=%0d exp_err_at=1", q_er.size()); end
      n_cmp++; if (q_rd.size() !== 0) begin n_mis++; $display("FAIL err_bw_nreads got=%0d exp=0", q_rd.size()); end
      n_cmp++; if (n_done !== 0) begin n_mis++; $display("FAIL err_bw_ndone got=%0d exp=0", n_done); end
      n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL err_bw_busy got=%b exp=0", busy); end
      run_seq(2'd0, 2'd0, 4'b1110, 4'b0000, 4'd1, -1, 0, 1'b0);
      n_cmp++; if (n_err !== 1) begin n_mis++; $display("FAIL err_empty_pulses got=%0d exp=1", n_err); end
      n_cmp++; if (q_rd.size() !== 0) begin n_mis++; $display("FAIL err_empty_nreads got=%0d exp=0", q_rd.size()); end
      n_cmp++; if (n_done !== 0) begin n_mis++; $display("FAIL err_empty_ndone got=%0d exp=0", n_done); end
`else
      run_seq(2'd2, 2'd1, 4'b1111, 4'b0000, 4'd1, -1, 0, 1'b0);
      n_cmp++; if (q_rd.size() !== 256) begin n_mis++; $display("FAIL nochk_nreads got=%0d exp=256", q_rd.size()); end
      for (int i = 0; i < q_rd.size() && i < 256; i++) begin
         n_cmp++; if (q_rd[i] !== 8'(i)) begin n_mis++; $display("FAIL nochk_addr[%0d] got=%0d exp=%0d", i, q_rd[i], i); end
      end
      n_cmp++; if (n_err !== 0) begin n_mis++; $display("FAIL nochk_err got=%0d exp=0", n_err); end
      n_cmp++; if (n_done !== 1) begin n_mis++; $display("FAIL nochk_ndone got=%0d exp=1", n_done); end
      run_seq(2'd0, 2'd0, 4'b1110, 4'b0000, 4'd1, -1, 0, 1'b0);
      n_cmp++; if (q_rd.size() !== 0) begin n_mis++; $display("FAIL nochk_empty_nreads got=%0d exp=0", q_rd.size()); end
      n_cmp++; if (n_done !== 1) begin n_mis++; $display("FAIL nochk_empty_ndone got=%0d exp=1", n_done); end
      n_cmp++; if (n_err !== 0) begin n_mis++; $display("FAIL nochk_empty_err got=%0d exp=0", n_err); end
`endif
   endtask

   task automatic test_reset_mid();
      bit hit;
      int nd;
      txconfig_bw = 2'd1; sys_bw_mode = 2'd1; mask = 4'b0011; gamma = 4'b0011; n_tx = 4'd6;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (nhtp_re && nhtp_raddr == 8'd100) begin hit = 1'b1; break; end
         @(negedge clk);
      end
      n_cmp++; if (hit !== 1'b1) begin n_mis++; $display("FAIL rmid_reach100 got=%b exp=1", hit); end
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if ({nhtp_re, nhtp_gamma, nhtp_4ch, busy, done, cfg_err} !== 6'b0) begin
         n_mis++; $display("FAIL rmid_outputs got=%b exp=000000", {nhtp_re, nhtp_gamma, nhtp_4ch, busy, done, cfg_err});
      end
      n_cmp++; if (nhtp_raddr !== 8'd0) begin n_mis++; $display("FAIL rmid_raddr got=%0d exp=0", nhtp_raddr); end
      nd = 0;
      repeat (2) begin
         @(negedge clk);
         if (done) nd++;
      end
      n_cmp++; if (nd !== 0) begin n_mis++; $display("FAIL rmid_no_done got=%0d exp=0", nd); end
      reset_n = 1'b1;
      run_seq(2'd1, 2'd1, 4'b0011, 4'b0000, 4'd1, -1, 0, 1'b0);
      n_cmp++; if (first_re !== 2) begin n_mis++; $display("FAIL rmid_first_re got=%0d exp=2", first_re); end
      n_cmp++; if (q_rd.size() !== 128) begin n_mis++; $display("FAIL rmid_nreads got=%0d exp=128", q_rd.size()); end
      n_cmp++; if (q_rd.size() == 0 || q_rd[0] !== 8'd0) begin n_mis++; $display("FAIL rmid_first_addr got_len=%0d exp_addr=0", q_rd.size()); end
      n_cmp++; if (n_done !== 1) begin n_mis++; $display("FAIL rmid_ndone got=%0d exp=1", n_done); end
   endtask

   task automatic test_back_to_back();
      run_seq(2'd0, 2'd0, 4'b0001, 4'b0000, 4'd1, -1, 0, 1'b1);
      n_cmp++; if (q_rd.size() !== 64) begin n_mis++; $display("FAIL b2b_ignore_nreads got=%0d exp=64", q_rd.size()); end
      n_cmp++; if (q_rd.size() < 64 || q_rd[63] !== 8'd63) begin n_mis++; $display("FAIL b2b_ignore_last got_len=%0d exp_addr=63", q_rd.size()); end
      n_cmp++; if (n_done !== 1) begin n_mis++; $display("FAIL b2b_ignore_ndone got=%0d exp=1", n_done); end
      n_cmp++; if (n_gam !== 0) begin n_mis++; $display("FAIL b2b_ignore_gamma got=%0d exp=0", n_gam); end
      run_seq(2'd1, 2'd1, 4'b0010, 4'b1111, 4'd1, -1, 0, 1'b0);
      n_cmp++; if (first_re !== 2) begin n_mis++; $display("FAIL b2b_first_re got=%0d exp=2", first_re); end
      n_cmp++; if (q_rd.size() !== 64) begin n_mis++; $display("FAIL b2b_nreads got=%0d exp=64", q_rd.size()); end
      n_cmp++; if (q_rd.size() == 0 || q_rd[0] !== 8'd64) begin n_mis++; $display("FAIL b2b_first_addr got_len=%0d exp_addr=64", q_rd.size()); end
      n_cmp++; if (n_gam !== 64) begin n_mis++; $display("FAIL b2b_gamma got=%0d exp=64", n_gam); end
   endtask

   initial begin
      test_reset();
      test_single_20();
      test_skip_80();
      test_multichain();
      test_stall();
      test_cfg();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/qcs_dyn_pre_rd_seq.md
QCS_DYN_PRE_RD_SEQ -- requirements
Module: qcs_dyn_pre_rd_seq

Interface
REQ-001 SHALL have parameters, one per line: ADDR_DW, 8, read-address width; BW_W, 2, bandwidth code width; GAMMA_W, 4, gamma bits (one per 20 MHz subband); SUBBAND_W, 4, subband-present mask width; SEG_LEN, 64, samples per 20 MHz segment (power of 2).
REQ-002 SHALL have one clock, clk, and an asynchronous active-low reset, reset_n.
REQ-003 SHALL have ports, one per line (name  direction  width  meaning):
clk  in  1  clock
reset_n  in  1  async active-low reset
start  in  1  one-cycle request to read one preamble
txconfig_bw  in  BW_W  packet bandwidth code (0=20,1=40,2=80 MHz)
sys_bw_mode  in  BW_W  system bandwidth code
config_mu_subband_present  in  SUBBAND_W  bit i=1: subband i transmitted
config_gamma_rotation  in  GAMMA_W  per-subband gamma sign
n_tx  in  4  number of TX chains (0 treated as 1)
stall  in  1  downstream hold
nhtp_re  out  1  read enable
nhtp_raddr  out  ADDR_DW  read address
nhtp_gamma  out  1  gamma bit of current subband
nhtp_4ch  out  1  latched n_tx greater than 4
busy  out  1  sequence in progress
done  out  1  one-cycle end-of-sequence pulse
cfg_err  out  1  one-cycle illegal-config pulse

Function
REQ-004 SHALL latch txconfig_bw, sys_bw_mode, mask, gamma and n_tx on the clk edge where start=1 in IDLE; start while busy=1 SHALL be ignored.
REQ-005 SHALL implement FSM states IDLE, CHECK, READ, NEXT_SB, NEXT_TX, DONE: IDLE->CHECK on start; CHECK->READ at first present subband, else ->DONE; READ->NEXT_SB after SEG_LEN reads; NEXT_SB->READ at next present subband, else ->NEXT_TX; NEXT_TX->CHECK if chains remain, else ->DONE; DONE->IDLE.
REQ-006 Active subbands SHALL be 0..(1<<txconfig_bw)-1; txconfig_bw=3 SHALL be treated as 2; subbands with mask bit 0 SHALL be skipped with no reads.
REQ-007 In READ, nhtp_re SHALL be 1 exactly when stall=0; nhtp_raddr = subband*SEG_LEN + sample, sample 0..SEG_LEN-1 ascending, address truncated to ADDR_DW.
REQ-008 When stall=1, nhtp_re SHALL be 0 and sample, subband, chain counters and nhtp_raddr SHALL hold.
REQ-009 First nhtp_re SHALL be asserted 2 cycles after start is sampled (no stall, subband 0 present).
REQ-010 The subband sweep SHALL repeat once per TX chain, max(n_tx,1) times, with identical addresses.
REQ-011 nhtp_gamma SHALL equal the latched gamma bit of the current subband while nhtp_re=1, else 0.
REQ-012 nhtp_4ch SHALL be registered from the latched n_tx (>4) and hold until next start.
REQ-013 done SHALL pulse 1 cycle in DONE, the cycle after the last read; busy SHALL be 1 from CHECK through DONE inclusive.
REQ-014 All outputs SHALL be registered.

Reset
REQ-015 reset_n=0 SHALL immediately force IDLE and drive nhtp_re, nhtp_raddr, nhtp_gamma, nhtp_4ch, busy, done, cfg_err to 0, clearing counters and latched config.
REQ-016 Reset mid-sequence SHALL abort it with no done pulse; after release the block SHALL accept start in the first cycle.

Configuration
REQ-017 With QCS_DYN_PRE_RD_SEQ_ERR_CHK_EN defined, CHECK (first chain) SHALL detect txconfig_bw>sys_bw_mode or no present active subband, pulse cfg_err one cycle, return to IDLE, and issue no reads and no done.
REQ-018 Without QCS_DYN_PRE_RD_SEQ_ERR_CHK_EN, cfg_err SHALL be tied 0, no check is made, and an all-skipped config SHALL go to DONE with zero reads.

Verification
REQ-019 bw=0, sys=0, mask=0001, n_tx=1, no stall -> 64 reads, addr 0..63, first re 2 cycles after start, done next cycle after addr 63.
REQ-020 bw=2, mask=1011, gamma=0100, n_tx=1 -> 192 reads: 0..63, 64..127, 192..255; nhtp_gamma=0 throughout; subband 2 skipped.
REQ-021 bw=1, mask=0011, n_tx=6 -> 6x128 reads, nhtp_4ch=1, single done.
REQ-022 stall=1 for 5 cycles at addr 20 -> re=0 for 5 cycles, addr holds 20, resumes at 21 without loss.
REQ-023 ERR_CHK_EN, bw=2, sys=1 -> cfg_err pulse, no re, busy back to 0; without macro -> 256 reads.
REQ-024 reset_n low at addr 100 of bw=1 sequence -> outputs 0 at once, no done; new start after release reads from addr 0.
